// File: rtl/counter_dispatch_if.sv
// Handshake and status bundle between the ticket/call scheduler and its
// environment. The master side drives the button and per-counter controls;
// the slave side (the scheduler) drives ticket, queue and call status.
interface counter_dispatch_if;
  logic        button;
  logic [4:0]  counter_enable;
  logic [4:0]  counter_done;
  logic [5:0]  issued_number;
  logic [5:0]  waiting_count;
  logic        queue_full;
  logic        reject;
  logic        call_valid;
  logic [2:0]  counter_call;
  logic [5:0]  number_service;
  logic [4:0]  counter_busy;
  logic [29:0] service_numbers;

  modport master (
    output button, counter_enable, counter_done,
    input  issued_number, waiting_count, queue_full, reject, call_valid,
           counter_call, number_service, counter_busy, service_numbers
  );

  modport slave (
    input  button, counter_enable, counter_done,
    output issued_number, waiting_count, queue_full, reject, call_valid,
           counter_call, number_service, counter_busy, service_numbers
  );
endinterface

// File: rtl/counter_dispatch_arbiter.sv
// Ticket-and-call scheduler for five service counters (A..E = 0..4).
// Issues sequential tickets on button presses, counts waiting customers and
// calls the oldest waiting ticket to a free, open counter, one per cycle.
// Optional macro DISPATCH_ROUND_ROBIN_EN: circular grant search starting at
// rr_ptr; when undefined, the lowest eligible counter index wins.
module counter_dispatch_arbiter #(
  parameter int QUEUE_MAX  = 32,
  parameter int MAX_TICKET = 63
) (
  input logic          clk,
  input logic          rst,
  counter_dispatch_if.slave bus
);

  logic             button_q;
  logic [5:0]       issued_number;
  logic [5:0]       waiting_count;
  logic [5:0]       next_serve;
  logic             reject;
  logic             call_valid;
  logic [2:0]       counter_call;
  logic [5:0]       number_service;
  logic [4:0]       counter_busy;
  logic [4:0][5:0]  service_numbers;

  logic             press;
  logic             accept;
  logic [4:0]       elig;
  logic             dispatch;
  logic [2:0]       grant;
  logic [4:0]       grant_onehot;
  logic [4:0]       done_mask;

`ifdef DISPATCH_ROUND_ROBIN_EN
  logic [2:0]       rr_ptr;
  logic             found;
`endif

  // Ticket numbers run 1..MAX_TICKET and then restart at 1; 0 is never used.
  function automatic logic [5:0] wrap_inc(input logic [5:0] value);
    return (value == 6'(MAX_TICKET)) ? 6'd1 : value + 6'd1;
  endfunction

  // Press detection, queue admission and eligibility from registered busy.
  always_comb begin
    press     = bus.button & ~button_q;
    accept    = press && (waiting_count < 6'(QUEUE_MAX));
    elig      = bus.counter_enable & ~counter_busy;
    dispatch  = (waiting_count != 6'd0) && (elig != 5'd0);
    done_mask = bus.counter_done & counter_busy;
  end

`ifdef DISPATCH_ROUND_ROBIN_EN
  // Circular search for the first eligible counter at or after rr_ptr.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    grant = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (!found && elig[(int'(rr_ptr) + k) % 5]) begin
        grant = 3'((int'(rr_ptr) + k) % 5);
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scanning downward lets the lowest eligible index win.
  always_comb begin
    grant = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (elig[i]) grant = 3'(i);
    end
  end
`endif

  assign grant_onehot = 5'b00001 << grant;

  // Ticket issue, waiting count, call generation and per-counter service state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      button_q        <= 1'b0;
      issued_number   <= 6'd0;
      waiting_count   <= 6'd0;
      next_serve      <= 6'd1;
      reject          <= 1'b0;
      call_valid      <= 1'b0;
      counter_call    <= 3'b111;
      number_service  <= 6'd0;
      counter_busy    <= 5'd0;
      service_numbers <= '0;
`ifdef DISPATCH_ROUND_ROBIN_EN
      rr_ptr          <= 3'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, e.g. busy and waiting_count used by dispatch.
      button_q <= bus.button;
      reject   <= press & ~accept;

      if (accept) issued_number <= wrap_inc(issued_number);

      // A simultaneous issue and call leaves the count unchanged.
      case ({accept, dispatch})
        2'b10:   waiting_count <= waiting_count + 6'd1;
        2'b01:   waiting_count <= waiting_count - 6'd1;
        default: waiting_count <= waiting_count;
      endcase

      call_valid   <= dispatch;
      counter_call <= dispatch ? grant : 3'b111;

      if (dispatch) begin
        number_service         <= next_serve;
        service_numbers[grant] <= next_serve;
        next_serve             <= wrap_inc(next_serve);
`ifdef DISPATCH_ROUND_ROBIN_EN
        rr_ptr                 <= (grant == 3'd4) ? 3'd0 : grant + 3'd1;
`endif
      end

      // Grants only target idle counters and done only clears busy ones, so
      // the two masks never overlap; a freed counter is eligible next cycle.
      counter_busy <= (counter_busy & ~done_mask) |
                      (dispatch ? grant_onehot : 5'd0);
    end
  end

  assign bus.issued_number   = issued_number;
  assign bus.waiting_count   = waiting_count;
  assign bus.queue_full      = (waiting_count == 6'(QUEUE_MAX));
  assign bus.reject          = reject;
  assign bus.call_valid      = call_valid;
  assign bus.counter_call    = counter_call;
  assign bus.number_service  = number_service;
  assign bus.counter_busy    = counter_busy;
  assign bus.service_numbers = service_numbers;

endmodule

// File: tb/tb_counter_dispatch_arbiter.sv
// Self-checking bench for counter_dispatch_arbiter. Directed stimulus pushes
// the expected calls into a scoreboard; a monitor on the falling edge pops
// and compares each call the scheduler makes.
module tb_counter_dispatch_arbiter;

  typedef struct {
    logic [2:0] ctr;
    logic [5:0] num;
  } call_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks   = 0;
  int    failures = 0;
  call_t sb[$];
  call_t got;

  always #5 clk = ~clk;

  counter_dispatch_if bus ();

  counter_dispatch_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every presented call must match the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.call_valid) begin
        check("call_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          check("call_counter", bus.counter_call, got.ctr);
          check("call_number", bus.number_service, got.num);
          check("call_service_slot", bus.service_numbers[6*got.ctr +: 6], got.num);
        end
      end else begin
        check("idle_counter_call", bus.counter_call, 7);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int ctr, input int num);
    call_t c;
    c.ctr = 3'(ctr);
    c.num = 6'(num);
    sb.push_back(c);
  endtask

  task automatic do_reset();
    check("scoreboard_drained", sb.size(), 0);
    sb.delete();
    rst = 1'b1;
    bus.button = 1'b0;
    bus.counter_done = 5'd0;
    #2;
    rst = 1'b0;
    tick(1);
  endtask

  // Button high for one edge; returns 1 ns after the press edge.
  task automatic press_pulse();
    bus.button = 1'b1;
    tick(1);
    bus.button = 1'b0;
  endtask

  task automatic press_spaced();
    press_pulse();
    tick(1);
  endtask

  task automatic done_pulse(input logic [4:0] mask);
    bus.counter_done = mask;
    tick(1);
    bus.counter_done = 5'd0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_issued"}, bus.issued_number, 0);
    check({tag, "_waiting"}, bus.waiting_count, 0);
    check({tag, "_queue_full"}, bus.queue_full, 0);
    check({tag, "_reject"}, bus.reject, 0);
    check({tag, "_call_valid"}, bus.call_valid, 0);
    check({tag, "_counter_call"}, bus.counter_call, 7);
    check({tag, "_number_service"}, bus.number_service, 0);
    check({tag, "_busy"}, bus.counter_busy, 0);
    check({tag, "_service_numbers"}, bus.service_numbers, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.button = 1'b0;
    bus.counter_enable = 5'd0;
    bus.counter_done = 5'd0;

    // 1: single press with all counters open.
    do_reset();
    bus.counter_enable = 5'h1F;
    check_reset_state("reset");
    push(0, 1);
    press_pulse();
    check("t1_issued", bus.issued_number, 1);
    check("t1_waiting", bus.waiting_count, 1);
    check("t1_no_call_yet", bus.call_valid, 0);
    tick(1);
    check("t1_call_valid", bus.call_valid, 1);
    check("t1_counter_call", bus.counter_call, 0);
    check("t1_number", bus.number_service, 1);
    check("t1_busy", bus.counter_busy, 5'b00001);
    check("t1_waiting_after", bus.waiting_count, 0);
    tick(1);

    // 2: six presses, five counters; done on C serves the sixth ticket.
    do_reset();
    bus.counter_enable = 5'h1F;
    for (int k = 0; k < 5; k++) push(k, k + 1);
    repeat (6) press_spaced();
    check("t2_waiting", bus.waiting_count, 1);
    check("t2_busy_all", bus.counter_busy, 5'h1F);
    check("t2_issued", bus.issued_number, 6);
    push(2, 6);
    done_pulse(5'b00100);
    check("t2_busy_after_done", bus.counter_busy, 5'b11011);
    tick(1);
    check("t2_recall_counter", bus.counter_call, 2);
    check("t2_recall_number", bus.number_service, 6);
    check("t2_waiting_after", bus.waiting_count, 0);
    check("t2_busy_refill", bus.counter_busy, 5'h1F);
    tick(1);

    // 3: fill the queue with all counters closed, then one press too many.
    do_reset();
    bus.counter_enable = 5'd0;
    repeat (32) press_spaced();
    check("t3_waiting", bus.waiting_count, 32);
    check("t3_queue_full", bus.queue_full, 1);
    check("t3_issued", bus.issued_number, 32);
    check("t3_no_reject_yet", bus.reject, 0);
    press_pulse();
    check("t3_reject", bus.reject, 1);
    check("t3_issued_held", bus.issued_number, 32);
    check("t3_waiting_held", bus.waiting_count, 32);
    tick(1);
    check("t3_reject_pulse", bus.reject, 0);

    // 4: a held button issues one ticket only.
    do_reset();
    bus.counter_enable = 5'd0;
    bus.button = 1'b1;
    tick(10);
    bus.button = 1'b0;
    tick(1);
    check("t4_issued", bus.issued_number, 1);
    check("t4_waiting", bus.waiting_count, 1);

    // 5: 64 tickets through counter A; ticket 64 is issued as 1.
    do_reset();
    bus.counter_enable = 5'b00001;
    for (int k = 1; k <= 64; k++) begin
      push(0, ((k - 1) % 63) + 1);
      press_pulse();
      if (k == 63) check("t5_issued_63", bus.issued_number, 63);
      if (k == 64) check("t5_issued_wrap", bus.issued_number, 1);
      tick(1);
      done_pulse(5'b00001);
    end
    check("t5_last_number", bus.number_service, 1);

    // 6a: all busy, rr_ptr at 0, done on A and C together.
    do_reset();
    bus.counter_enable = 5'h1F;
    for (int k = 0; k < 5; k++) push(k, k + 1);
    repeat (5) press_spaced();
    push(0, 6);
    push(2, 7);
    repeat (2) press_spaced();
    check("t6a_waiting", bus.waiting_count, 2);
    done_pulse(5'b00101);
    check("t6a_no_same_cycle_grant", bus.call_valid, 0);
    tick(3);
    check("t6a_waiting_after", bus.waiting_count, 0);
    check("t6a_busy", bus.counter_busy, 5'h1F);

    // 6b: same, but with rr_ptr moved to 1 by an extra grant on A.
    do_reset();
    bus.counter_enable = 5'h1F;
    for (int k = 0; k < 5; k++) push(k, k + 1);
    repeat (5) press_spaced();
    done_pulse(5'b00001);
    push(0, 6);
    press_spaced();
`ifdef DISPATCH_ROUND_ROBIN_EN
    push(2, 7);
    push(0, 8);
`else
    push(0, 7);
    push(2, 8);
`endif
    repeat (2) press_spaced();
    check("t6b_waiting", bus.waiting_count, 2);
    done_pulse(5'b00101);
    tick(3);
    check("t6b_waiting_after", bus.waiting_count, 0);
    check("t6b_busy", bus.counter_busy, 5'h1F);

    // 7: asynchronous reset while a call is being presented.
    do_reset();
    bus.counter_enable = 5'h1F;
    press_pulse();
    tick(1);
    check("t7_call_before_reset", bus.call_valid, 1);
    check("t7_busy_before_reset", bus.counter_busy, 5'b00001);
    rst = 1'b1;
    #1;
    check_reset_state("t7_async");
    #1;
    rst = 1'b0;
    tick(2);
    check("t7_issued_after", bus.issued_number, 0);
    check("t7_busy_after", bus.counter_busy, 0);

    tick(2);
    check("final_scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
